instr_sequencer: RTL

Multi-cycle control sequencer for the 16-bit RISC core. It latches each fetched instruction, decodes its opcode class, and drives the program-counter select code (`ps`), branch offset (`extend`), execute strobe and memory request. It also waits on the data-memory handshake, halts on `HLT`, and counts retired instructions. It sits between instruction memory and the PC/datapath and is the sole driver of the PC's `PS` and `extend` inputs.

---
 rtl/seq_pkg.sv | 42 ++++
 rtl/seq_decode.sv | 24 ++
 rtl/instr_sequencer.sv | 122 ++++++++++++
 3 files changed

// File: rtl/seq_pkg.sv
// Shared types and encodings for the instruction sequencer: FSM states,
// PC-select codes and decoded opcode classes.
package seq_pkg;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_MEMW  = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    localparam logic [1:0] PS_HOLD = 2'b00;
    localparam logic [1:0] PS_INC  = 2'b01;
    localparam logic [1:0] PS_REL  = 2'b10;
    localparam logic [1:0] PS_ABS  = 2'b11;

    typedef enum logic [2:0] {
        OP_NOP = 3'd0,
        OP_ALU = 3'd1,
        OP_LD  = 3'd2,
        OP_ST  = 3'd3,
        OP_BRZ = 3'd4,
        OP_BRN = 3'd5,
        OP_JMP = 3'd6,
        OP_HLT = 3'd7
    } op_class_t;

    // Opcodes E and F have no class of their own; they run as NOP.
    function automatic op_class_t class_of(input logic [3:0] opcode);
        case (opcode)
            4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7: class_of = OP_ALU;
            4'h8:    class_of = OP_LD;
            4'h9:    class_of = OP_ST;
            4'hA:    class_of = OP_BRZ;
            4'hB:    class_of = OP_BRN;
            4'hC:    class_of = OP_JMP;
            4'hD:    class_of = OP_HLT;
            default: class_of = OP_NOP;
        endcase
    endfunction

endpackage

// File: rtl/seq_decode.sv
// Combinational instruction decode: opcode class, branch resolution and
// store qualifier from the latched instruction and datapath flags.
module seq_decode
    import seq_pkg::*;
(
    input  logic [15:0] ir,
    input  logic        flag_z,
    input  logic        flag_n,
    output op_class_t   op_class,
    output logic        branch_taken,
    output logic        mem_we
);

    logic ir_unused;
    assign ir_unused = ^ir[11:0];

    always_comb begin
        op_class     = class_of(ir[15:12]);
        branch_taken = ((op_class == OP_BRZ) && flag_z) ||
                       ((op_class == OP_BRN) && flag_n);
        mem_we       = (op_class == OP_ST);
    end

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle control sequencer: fetch/execute FSM, instruction register and
// retired-instruction counter. Define SEQ_STEP_EN to add single-step ports.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_FETCH | load IR from instr memory (stalls in step mode w/o step)
// ST_EXEC  | execute decoded class, drive ps for the next PC
// ST_MEMW  | data memory request outstanding, waiting for mem_ready
// ST_HALT  | stopped after HLT, only reset leaves
module instr_sequencer
    import seq_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [15:0]      instr,
    input  logic             flag_z,
    input  logic             flag_n,
    input  logic             mem_ready,
`ifdef SEQ_STEP_EN
    input  logic             step_mode,
    input  logic             step,
`endif
    output logic [1:0]       ps,
    output logic [5:0]       extend,
    output logic             il,
    output logic             ex_en,
    output logic             mem_req,
    output logic             mem_we,
    output logic             halted,
    output logic [CNT_W-1:0] retired
);

    state_t    state;
    state_t    next_state;
    logic [15:0] ir;
    op_class_t op_class;
    logic      branch_taken;
    logic      dec_mem_we;
    logic      fetch_go;
    logic      retire;

    seq_decode u_decode (
        .ir           (ir),
        .flag_z       (flag_z),
        .flag_n       (flag_n),
        .op_class     (op_class),
        .branch_taken (branch_taken),
        .mem_we       (dec_mem_we)
    );

`ifdef SEQ_STEP_EN
    assign fetch_go = !step_mode || step;
`else
    assign fetch_go = 1'b1;
`endif

    assign extend = ir[5:0];
    assign mem_we = mem_req && dec_mem_we;

    always_comb begin
        next_state = state;
        il         = 1'b0;
        ps         = PS_HOLD;
        ex_en      = 1'b0;
        mem_req    = 1'b0;
        halted     = 1'b0;
        case (state)
            ST_FETCH: begin
                if (fetch_go) begin
                    il         = 1'b1;
                    next_state = ST_EXEC;
                end
            end
            ST_EXEC: begin
                next_state = ST_FETCH;
                case (op_class)
                    OP_ALU: begin
                        ex_en = 1'b1;
                        ps    = PS_INC;
                    end
                    OP_LD, OP_ST: begin
                        mem_req = 1'b1;
                        if (mem_ready) ps = PS_INC;
                        else           next_state = ST_MEMW;
                    end
                    OP_BRZ, OP_BRN: ps = branch_taken ? PS_REL : PS_INC;
                    OP_JMP:         ps = PS_ABS;
                    OP_HLT:         next_state = ST_HALT;
                    default:        ps = PS_INC;
                endcase
            end
            ST_MEMW: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ps         = PS_INC;
                    next_state = ST_FETCH;
                end
            end
            default: halted = 1'b1;
        endcase
    end

    assign retire = ((state == ST_EXEC) || (state == ST_MEMW)) &&
                    (next_state == ST_FETCH);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_FETCH;
            ir      <= '0;
            retired <= '0;
        end else begin
            state <= next_state;
            if (il)
                ir <= instr;
            if (retire)
                retired <= retired + CNT_W'(1);
        end
    end

endmodule
